// File: rtl/disp_pkg.sv
// disp_pkg
// Shared types and helpers for the seven-segment scan scheduler:
//   state_e      - scheduler state (IDLE, SHOW, GAP)
//   SEG_BLANK    - segment pattern for a dark digit (active-low, all off)
//   LED_OFF      - anode pattern with every digit disabled (active-low)
//   seg_decode   - hex nibble to active-low {dp,g,f,e,d,c,b,a}, dp off
//   owner_onehot - 2-bit source index to 3-bit one-hot grant vector
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] LED_OFF   = 8'hFF;

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0:    pat = 8'hC0;
            4'h1:    pat = 8'hF9;
            4'h2:    pat = 8'hA4;
            4'h3:    pat = 8'hB0;
            4'h4:    pat = 8'h99;
            4'h5:    pat = 8'h92;
            4'h6:    pat = 8'h82;
            4'h7:    pat = 8'hF8;
            4'h8:    pat = 8'h80;
            4'h9:    pat = 8'h90;
            4'hA:    pat = 8'h88;
            4'hB:    pat = 8'h83;
            4'hC:    pat = 8'hC6;
            4'hD:    pat = 8'hA1;
            4'hE:    pat = 8'h86;
            4'hF:    pat = 8'h8E;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    function automatic logic [2:0] owner_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/seg_rr_arb.sv
// seg_rr_arb
// Three-way round-robin arbiter. The search starts at the source after the
// last one granted; last_owner only moves when upd is pulsed, so the caller
// decides when an arbitration result is committed.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req[2:0]    - request levels
//   upd         - commit winner as the new last owner
//   winner[1:0] - index of the selected source (valid when found=1)
//   found       - at least one source is requesting
module seg_rr_arb
    import disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       upd,
    output logic [1:0] winner,
    output logic       found
);

    logic [1:0] last_r;
    logic [1:0] o0_s;
    logic [1:0] o1_s;
    logic [1:0] o2_s;

    // Rotate the search order so the previous owner is checked last.
    always_comb begin
        case (last_r)
            2'd0: begin
                o0_s = 2'd1;
                o1_s = 2'd2;
                o2_s = 2'd0;
            end
            2'd1: begin
                o0_s = 2'd2;
                o1_s = 2'd0;
                o2_s = 2'd1;
            end
            default: begin
                o0_s = 2'd0;
                o1_s = 2'd1;
                o2_s = 2'd2;
            end
        endcase

        if (req[o0_s]) begin
            winner = o0_s;
            found  = 1'b1;
        end else if (req[o1_s]) begin
            winner = o1_s;
            found  = 1'b1;
        end else if (req[o2_s]) begin
            winner = o2_s;
            found  = 1'b1;
        end else begin
            winner = last_r;
            found  = 1'b0;
        end
    end

    // Last-owner register; reset to 2 so source 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 2'd2;
        end else if (upd) begin
            last_r <= winner;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/disp_scan_sched.sv
// disp_scan_sched
// Time-division scan scheduler for a shared 8-digit common-anode display.
// One of three sources owns the display; ownership is re-evaluated only at
// frame boundaries (start of a digit-0 slot), honours a minimum hold while
// contested, and every ownership change inserts one dark GAP slot.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   req[2:0]             - per-source request levels
//   data0..2[31:0]       - per-source hex words, nibble k on digit k
//   mask0..2[7:0]        - per-source digit enables, 0 blanks the digit
//   grant[2:0]           - one-hot current owner, 0 when idle
//   led_en[7:0]          - anode enables, active-low
//   seg[7:0]             - {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick           - one-cycle pulse at the start of each frame
module disp_scan_sched
    import disp_pkg::*;
#(
    parameter int SCAN_DIV    = 20000,
    parameter int HOLD_FRAMES = 250
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [7:0]  mask0,
    input  logic [7:0]  mask1,
    input  logic [7:0]  mask2,
    output logic [2:0]  grant,
    output logic [7:0]  led_en,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_FRAMES);

    logic [DW-1:0] div_r;
    state_e        st_r;
    // idx_r is the digit of the slot that starts at the next terminal count.
    logic [2:0]    idx_r;
    // owner_r is the shown source in SHOW and the incoming source in GAP.
    logic [1:0]    owner_r;
    logic [HW-1:0] hold_r;
    logic [2:0]    grant_r;
    logic [7:0]    led_r;
    logic [7:0]    seg_r;
    logic          tick_r;

    logic          tc_s;
    logic          boundary_s;
    logic          owner_req_s;
    logic          others_s;
    logic          start_s;
    logic          switch_s;
    logic          release_s;
    logic          arb_upd_s;
    logic [1:0]    win_s;
    logic          win_ok_s;
    logic [31:0]   sel_data_s;
    logic [7:0]    sel_mask_s;
    logic [3:0]    nib_s;
    logic [7:0]    dig_led_s;
    logic [7:0]    dig_seg_s;

    seg_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .upd    (arb_upd_s),
        .winner (win_s),
        .found  (win_ok_s)
    );

    // Frame-boundary arbitration decisions.
    always_comb begin
        tc_s        = (div_r == DIV_LAST);
        boundary_s  = tc_s && (idx_r == 3'd0);
        owner_req_s = |(req & owner_onehot(owner_r));
        others_s    = |(req & ~owner_onehot(owner_r));
        start_s     = 1'b0;
        switch_s    = 1'b0;
        release_s   = 1'b0;
        if (boundary_s && (st_r == IDLE)) begin
            start_s = win_ok_s;
        end else if (boundary_s && (st_r == SHOW)) begin
            if (!owner_req_s) begin
                switch_s  = win_ok_s;
                release_s = !win_ok_s;
            end else begin
                // A contested owner yields only once its hold has run out.
                switch_s = others_s && (hold_r >= HOLD_LIM);
            end
        end else begin
            start_s = 1'b0;
        end
        arb_upd_s = start_s | switch_s;
    end

    // Pattern for digit idx_r of the current/incoming owner, sampled at slot start.
    always_comb begin
        case (owner_r)
            2'd0: begin
                sel_data_s = data0;
                sel_mask_s = mask0;
            end
            2'd1: begin
                sel_data_s = data1;
                sel_mask_s = mask1;
            end
            2'd2: begin
                sel_data_s = data2;
                sel_mask_s = mask2;
            end
            default: begin
                sel_data_s = 32'h0000_0000;
                sel_mask_s = 8'h00;
            end
        endcase
        nib_s = sel_data_s[{idx_r, 2'b00} +: 4];
        if (sel_mask_s[idx_r]) begin
            dig_led_s = ~(8'h01 << idx_r);
            dig_seg_s = seg_decode(nib_s);
        end else begin
            dig_led_s = LED_OFF;
            dig_seg_s = SEG_BLANK;
        end
    end

    // Slot divider: terminal count marks the end of the current digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= {DW{1'b0}};
        end else if (tc_s) begin
            div_r <= {DW{1'b0}};
        end else begin
            div_r <= div_r + DW'(1);
        end
    end

    // Scheduler FSM with registered display outputs; everything moves at slot start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_r    <= IDLE;
            idx_r   <= 3'd0;
            owner_r <= 2'd0;
            hold_r  <= {HW{1'b0}};
            grant_r <= 3'b000;
            led_r   <= LED_OFF;
            seg_r   <= SEG_BLANK;
            tick_r  <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            if (tc_s) begin
                case (st_r)
                    IDLE: begin
                        tick_r <= boundary_s;
                        led_r  <= LED_OFF;
                        seg_r  <= SEG_BLANK;
                        if (start_s) begin
                            // idx stays 0 so the GAP slot is followed by digit 0.
                            st_r    <= GAP;
                            owner_r <= win_s;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end
                    GAP: begin
                        st_r    <= SHOW;
                        grant_r <= owner_onehot(owner_r);
                        hold_r  <= {HW{1'b0}};
                        led_r   <= dig_led_s;
                        seg_r   <= dig_seg_s;
                        idx_r   <= idx_r + 3'd1;
                        tick_r  <= 1'b1;
                    end
                    SHOW: begin
                        if (switch_s) begin
                            // Old grant stays visible through the dark slot.
                            st_r    <= GAP;
                            owner_r <= win_s;
                            led_r   <= LED_OFF;
                            seg_r   <= SEG_BLANK;
                        end else if (release_s) begin
                            st_r    <= IDLE;
                            grant_r <= 3'b000;
                            led_r   <= LED_OFF;
                            seg_r   <= SEG_BLANK;
                            idx_r   <= idx_r + 3'd1;
                            tick_r  <= 1'b1;
                        end else begin
                            led_r <= dig_led_s;
                            seg_r <= dig_seg_s;
                            idx_r <= idx_r + 3'd1;
                            if (boundary_s) begin
                                tick_r <= 1'b1;
                                if (hold_r < HOLD_LIM) begin
                                    hold_r <= hold_r + HW'(1);
                                end else begin
                                    hold_r <= hold_r;
                                end
                            end else begin
                                hold_r <= hold_r;
                            end
                        end
                    end
                    default: begin
                        st_r    <= IDLE;
                        idx_r   <= 3'd0;
                        grant_r <= 3'b000;
                        led_r   <= LED_OFF;
                        seg_r   <= SEG_BLANK;
                    end
                endcase
            end
        end
    end

    assign grant      = grant_r;
    assign led_en     = led_r;
    assign seg        = seg_r;
    assign frame_tick = tick_r;

endmodule

// File: tb/tb_disp_scan_sched.sv
// Testbench for disp_scan_sched: a slot-level behavioural model checks every
// cycle, a vector table checks the decoded digits of the first frames, and
// short directed sequences cover hold/rotation, owner drop and mid-scan reset.
module tb_disp_scan_sched;

    localparam int SD = 4;
    localparam int HF = 2;

    localparam logic [7:0] DEC [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [31:0] data0, data1, data2;
    logic [7:0]  mask0, mask1, mask2;
    logic [2:0]  grant;
    logic [7:0]  led_en;
    logic [7:0]  seg;
    logic        frame_tick;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (slot granularity)
    int         m_cnt, m_owner, m_pending, m_last, m_next, m_held;
    bit         m_gap;
    logic [7:0] e_led, e_seg;
    logic [2:0] e_grant;
    logic       e_tick;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  m;
        logic [7:0]  led;
        logic [7:0]  sg;
        logic        tk;
    } vec_t;
    vec_t tbl [24];

    always #5 clk = ~clk;

    disp_scan_sched #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .data2      (data2),
        .mask0      (mask0),
        .mask1      (mask1),
        .mask2      (mask2),
        .grant      (grant),
        .led_en     (led_en),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, got, exp);
        end
    endtask

    task automatic m_reset();
        m_cnt = 0; m_owner = -1; m_pending = 0; m_last = 2; m_next = 0; m_held = 0;
        m_gap = 1'b0;
        e_led = 8'hFF; e_seg = 8'hFF; e_grant = 3'b000; e_tick = 1'b0;
    endtask

    function automatic int rr_pick(input logic [2:0] r);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_last + k) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic blank();
        e_led = 8'hFF;
        e_seg = 8'hFF;
    endtask

    task automatic show_digit(input int d);
        logic [31:0] dw;
        logic [7:0]  mw;
        case (m_owner)
            0: begin dw = data0; mw = mask0; end
            1: begin dw = data1; mw = mask1; end
            default: begin dw = data2; mw = mask2; end
        endcase
        if (mw[d]) begin
            e_led = ~(8'h01 << d);
            e_seg = DEC[dw[4*d +: 4]];
        end else begin
            blank();
        end
    endtask

    // What the display should do at the start of a new digit slot.
    task automatic m_slot();
        int  w;
        bit  own, others;
        if (m_gap) begin
            m_gap = 1'b0; m_owner = m_pending; m_held = 0;
            e_grant = 3'b001 << m_owner;
            show_digit(0); m_next = 1; e_tick = 1'b1;
        end else if (m_owner < 0) begin
            blank();
            if (m_next == 0) begin
                e_tick = 1'b1;
                w = rr_pick(req);
                if (w >= 0) begin m_pending = w; m_last = w; m_gap = 1'b1; end
            end
            if (!m_gap) m_next = (m_next + 1) % 8;
        end else if (m_next != 0) begin
            show_digit(m_next);
            m_next = (m_next + 1) % 8;
        end else begin
            own    = req[m_owner];
            others = (req & ~(3'b001 << m_owner)) != 3'b000;
            if (!own && req == 3'b000) begin
                m_owner = -1; e_grant = 3'b000; blank(); e_tick = 1'b1; m_next = 1;
            end else if (!own || (others && m_held >= HF)) begin
                w = rr_pick(req); m_pending = w; m_last = w; m_gap = 1'b1; blank();
            end else begin
                if (m_held < HF) m_held++;
                e_tick = 1'b1; show_digit(0); m_next = 1;
            end
        end
    endtask

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic tick_cycle();
        @(posedge clk);
        if (!rst_n) begin
            m_reset();
        end else begin
            e_tick = 1'b0;
            m_cnt++;
            if (m_cnt == SD) begin
                m_cnt = 0;
                m_slot();
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({led_en, seg, grant, frame_tick} !== {e_led, e_seg, e_grant, e_tick}) begin
            n_bad++;
            $display("FAIL model at %0t: got led_en=%h seg=%h grant=%b tick=%b, want led_en=%h seg=%h grant=%b tick=%b",
                     $time, led_en, seg, grant, frame_tick, e_led, e_seg, e_grant, e_tick);
        end
    endtask

    task automatic wait_grant(input logic [2:0] g, input int budget, input string nm);
        int k;
        k = 0;
        while (grant !== g && k < budget) begin
            tick_cycle();
            k++;
        end
        check(nm, {29'd0, grant}, {29'd0, g});
    endtask

    initial begin
        // Table: three frames of owner 0 right after the first GAP slot.
        for (int i = 0; i < 24; i++) begin
            int dig, frm;
            dig = i % 8;
            frm = i / 8;
            tbl[i].d  = (frm == 1) ? 32'hFEDC_BA98 : 32'h7654_3210;
            tbl[i].m  = (frm == 2) ? 8'h0F : 8'hFF;
            tbl[i].tk = (dig == 0);
            if (frm == 2 && dig >= 4) begin
                tbl[i].led = 8'hFF;
                tbl[i].sg  = 8'hFF;
            end else begin
                tbl[i].led = ~(8'h01 << dig);
                tbl[i].sg  = DEC[(frm == 1) ? dig + 8 : dig];
            end
        end

        rst_n = 1'b0;
        req   = 3'b001;
        data0 = 32'h7654_3210; mask0 = 8'hFF;
        data1 = 32'h89AB_CDEF; mask1 = 8'hFF;
        data2 = 32'h1357_9BDF; mask2 = 8'hF0;
        m_reset();
        repeat (3) @(negedge clk);
        check("reset_led", {24'd0, led_en}, 32'h0000_00FF);
        check("reset_seg", {24'd0, seg}, 32'h0000_00FF);
        check("reset_grant", {29'd0, grant}, 32'd0);
        rst_n = 1'b1;

        // First slot is the dark GAP, still ungranted.
        repeat (SD) tick_cycle();
        check("gap_led", {24'd0, led_en}, 32'h0000_00FF);
        check("gap_grant", {29'd0, grant}, 32'd0);
        check("gap_tick", {31'd0, frame_tick}, 32'd1);

        for (int i = 0; i < 24; i++) begin
            data0 = tbl[i].d;
            mask0 = tbl[i].m;
            repeat (SD) tick_cycle();
            check($sformatf("vec%0d_led", i), {24'd0, led_en}, {24'd0, tbl[i].led});
            check($sformatf("vec%0d_seg", i), {24'd0, seg}, {24'd0, tbl[i].sg});
            check($sformatf("vec%0d_grant", i), {29'd0, grant}, 32'd1);
            check($sformatf("vec%0d_tick", i), {31'd0, frame_tick}, {31'd0, tbl[i].tk});
        end

        // Contention: rotate 0 -> 1, then with all requesting 1 -> 2.
        req = 3'b011;
        wait_grant(3'b010, 300, "rotate_to_1");
        req = 3'b111;
        wait_grant(3'b100, 300, "rotate_to_2");

        // Owner drops mid-frame with nobody else requesting.
        repeat (13) tick_cycle();
        req = 3'b000;
        wait_grant(3'b000, 200, "drop_to_idle");
        repeat (40) tick_cycle();
        check("idle_led", {24'd0, led_en}, 32'h0000_00FF);

        // Asynchronous reset while digit 3 is lit.
        req = 3'b001;
        begin
            int k;
            k = 0;
            while (led_en !== 8'hF7 && k < 400) begin
                tick_cycle();
                k++;
            end
            check("reach_digit3", {24'd0, led_en}, 32'h0000_00F7);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_led", {24'd0, led_en}, 32'h0000_00FF);
        check("async_seg", {24'd0, seg}, 32'h0000_00FF);
        check("async_grant", {29'd0, grant}, 32'd0);
        check("async_tick", {31'd0, frame_tick}, 32'd0);
        repeat (2) tick_cycle();
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 47) == 0) req = 3'($urandom_range(0, 7));
            data0 = $urandom; data1 = $urandom; data2 = $urandom;
            mask0 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            mask1 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            mask2 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            tick_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/disp_scan_sched.md
# disp_scan_sched

Time-division scan scheduler and arbiter for the shared 8-digit common-anode seven-segment display. Up to three requesters (timer, counter, ID/banner logic) each present a 32-bit hex word and a digit mask. The block grants the display to one of them with round-robin, frame-aligned arbitration and a minimum hold time, then scans the owner's digits and drives registered anode enables and segment lines.

## Interface
Parameters:
- SCAN_DIV, 20000: clk cycles per digit slot (≥2).
- HOLD_FRAMES, 250: minimum frames an owner keeps the display while another source requests (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  3  per-source display request, level
- data0, data1, data2  in  32 each  eight hex nibbles; nibble k (bits 4k+3:4k) shows on digit k
- mask0, mask1, mask2  in  8 each  digit enable per source; bit k=0 blanks digit k
- grant  out  3  one-hot current owner, 0 when idle
- led_en  out  8  anode enables, active-low
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low
- frame_tick  out  1  one-cycle pulse at the start of each digit-0 slot

## Operation
- Divider counts 0..SCAN_DIV-1. At terminal count, digit index idx advances 0→7, then wraps to 0. A wrap is a frame boundary.
- States:
  - IDLE: grant=0, display blank.
  - SHOW: owner's digits are scanned.
  - GAP: one blank digit slot (led_en=FF) inserted on every ownership change to prevent ghosting.
- Arbitration is evaluated only at frame boundaries:
  - IDLE with any req goes to GAP. At the next slot end it goes to SHOW with grant = winner.
  - SHOW, owner req low: go to IDLE if no req, else to GAP and switch to the winner.
  - SHOW, owner req high, another req high, and hold_cnt ≥ HOLD_FRAMES: go to GAP and switch to the winner. Otherwise stay in SHOW.
- Winner search order: last_owner+1, +2, +3 (mod 3). last_owner resets to 2, so source 0 has first priority.
- hold_cnt clears on grant and increments each frame boundary while in SHOW, saturating.
- After GAP, scanning resumes at idx=0.
- During SHOW, for each slot:
  - led_en = ~(8'b1<<idx) if mask_owner[idx]=1, else 8'hFF.
  - seg = decode(nibble idx of data_owner), dp always 1.
  - data and mask are sampled at slot start and are stable for the whole slot.
- Decode (active-low hex): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- A blanked digit drives seg=8'hFF.

## Timing
- Reset values: led_en=8'hFF, seg=8'hFF, grant=3'b000, frame_tick=0. Internal state: IDLE, idx=0, divider=0, hold_cnt=0.
- led_en, seg and grant are registered and update on the same edge, one cycle after divider terminal count. Enable and segment data never disagree.
- frame_tick is high for exactly one cycle, coincident with the led_en update for digit 0 in SHOW. It also pulses in IDLE at frame boundaries.
- req changes mid-frame have no effect until the next frame boundary. Worst-case grant latency is 2 frames + 1 slot.
- Owner drops req mid-frame: the current frame completes with the owner's data.
- Simultaneous req at a boundary: round-robin order decides.
- rst_n assertion mid-scan: outputs go to reset values immediately (asynchronous). Release: the first slot begins SCAN_DIV cycles later.

## Structure
- Package disp_pkg holds:
  - state enum {IDLE, SHOW, GAP};
  - hex-to-segment constant array / function seg_decode;
  - SEG_BLANK=8'hFF and LED_OFF=8'hFF.
- One sub-module, seg_rr_arb (3-way round-robin with last_owner register and update enable). Divider, FSM and output registers stay in the top.

## Test plan
Run all scenarios with SCAN_DIV=4 and HOLD_FRAMES=2.
- Reset, req=0 → led_en=FF, seg=FF, grant=0 for ≥5 frames; frame_tick every 32 cycles.
- req=001, data0=32'h76543210, mask0=FF → after one GAP slot, grant=001. Digits 0..7 show C0,F9,A4,B0,99,92,82,F8 with led_en FE,FD,…,7F.
- mask0=8'h0F → digits 4..7 have led_en=FF and seg=FF; digits 0..3 are unchanged.
- Owner 0 active, req raised to 011 at frame 0 → grant stays 001 until hold_cnt=2. Then one GAP slot, then grant=010. With req=111, the next switch goes to 100.
- Owner drops req mid-frame → the frame completes, then a GAP slot. grant=0 and state IDLE if no other req.
- rst_n pulsed low mid-digit-3 → outputs are FF/FF/0 within the same cycle. After release, the sequence restarts from IDLE.
